// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game state machine.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } game_state_t;

    localparam int MAX_LIVES_DEFAULT = 3;
    localparam int MAX_LEVEL_DEFAULT = 9;
    localparam logic [3:0] LEVEL_WRAP = 4'd1;

    function automatic logic [3:0] next_level(input logic [3:0] level, input logic [3:0] max_level);
        return (level >= max_level) ? LEVEL_WRAP : level + 4'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; a level already high when reset releases must drop once before it can fire.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= sig;
            armed <= armed | ~sig;
        end
    end

    assign rise = sig & ~prev & armed;

endmodule

// File: rtl/game_state_fsm.sv
// Game flow controller: lives, level, post-hit invulnerability and respawn requests.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int INVULN_CYCLES = 25_000_000,
    parameter int MAX_LIVES     = MAX_LIVES_DEFAULT,
    parameter int MAX_LEVEL     = MAX_LEVEL_DEFAULT
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Collision,
    input  logic       i_Goal_Reached,
    input  logic       i_Start,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Respawn,
    output logic       o_Invuln,
    output logic       o_Game_Over,
    output logic [1:0] o_State
);

    localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);

    game_state_t        state, state_n;
    logic [2:0]         lives_n;
    logic [3:0]         level_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic               respawn_n;
    logic               start_rise, goal_rise;

    edge_detect u_start_edge (
        .clk   (i_Clk),
        .reset (i_Reset),
        .sig   (i_Start),
        .rise  (start_rise)
    );

    edge_detect u_goal_edge (
        .clk   (i_Clk),
        .reset (i_Reset),
        .sig   (i_Goal_Reached),
        .rise  (goal_rise)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= ST_IDLE;
            o_Lives   <= 3'(MAX_LIVES);
            o_Level   <= LEVEL_WRAP;
            o_Respawn <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_n;
            o_Lives   <= lives_n;
            o_Level   <= level_n;
            o_Respawn <= respawn_n;
            timer     <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        lives_n   = o_Lives;
        level_n   = o_Level;
        timer_n   = timer;
        respawn_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_n   = ST_PLAY;
                    respawn_n = 1'b1;
                end
            end
            ST_PLAY: begin
                // Collision outranks a simultaneous goal edge.
                if (i_Collision) begin
                    if (o_Lives > 3'd1) begin
                        lives_n   = o_Lives - 3'd1;
                        respawn_n = 1'b1;
                        timer_n   = TIMER_LOAD;
                        state_n   = ST_HIT;
                    end else begin
                        lives_n = 3'd0;
                        state_n = ST_OVER;
                    end
                end else if (goal_rise) begin
                    level_n   = next_level(o_Level, 4'(MAX_LEVEL));
                    respawn_n = 1'b1;
                end
            end
            ST_HIT: begin
                if (timer == '0) begin
                    state_n = ST_PLAY;
                end else begin
                    timer_n = timer - 1'b1;
                end
                if (goal_rise) begin
                    level_n   = next_level(o_Level, 4'(MAX_LEVEL));
                    respawn_n = 1'b1;
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    lives_n   = 3'(MAX_LIVES);
                    level_n   = LEVEL_WRAP;
                    respawn_n = 1'b1;
                    state_n   = ST_PLAY;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Back-to-back requests collapse so the player controller sees isolated pulses.
        if (o_Respawn) respawn_n = 1'b0;
    end

    assign o_State     = state;
    assign o_Invuln    = (state == ST_HIT);
    assign o_Game_Over = (state == ST_OVER);

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm with a short invulnerability window.
module tb_game_state_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       collision = 1'b0;
    logic       goal = 1'b0;
    logic       start = 1'b0;
    logic [2:0] lives;
    logic [3:0] level;
    logic       respawn;
    logic       invuln;
    logic       game_over;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] level_seq [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};

    game_state_fsm #(.INVULN_CYCLES(8), .MAX_LIVES(3), .MAX_LEVEL(9)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Collision    (collision),
        .i_Goal_Reached (goal),
        .i_Start        (start),
        .o_Lives        (lives),
        .o_Level        (level),
        .o_Respawn      (respawn),
        .o_Invuln       (invuln),
        .o_Game_Over    (game_over),
        .o_State        (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_state, input logic [2:0] e_lives,
                             input logic [3:0] e_level, input logic e_respawn);
        check({tag, "_state"}, 32'(state), 32'(e_state));
        check({tag, "_lives"}, 32'(lives), 32'(e_lives));
        check({tag, "_level"}, 32'(level), 32'(e_level));
        check({tag, "_respawn"}, 32'(respawn), 32'(e_respawn));
        check({tag, "_invuln"}, 32'(invuln), 32'(e_state == 2'b10));
        check({tag, "_over"}, 32'(game_over), 32'(e_state == 2'b11));
    endtask

    initial begin
        // Reset with start already held high.
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check_all("reset", 2'b00, 3'd3, 4'd1, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        check_all("held_start", 2'b00, 3'd3, 4'd1, 1'b0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check_all("start", 2'b01, 3'd3, 4'd1, 1'b1);
        tick();
        check_all("start_pulse_end", 2'b01, 3'd3, 4'd1, 1'b0);
        start = 1'b0;

        // Collision held for 20 cycles.
        collision = 1'b1;
        tick();
        check_all("hold_hit1", 2'b10, 3'd2, 4'd1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_all("hold_invuln", 2'b10, 3'd2, 4'd1, 1'b0);
        end
        tick();
        check_all("hold_back_play", 2'b01, 3'd2, 4'd1, 1'b0);
        tick();
        check_all("hold_hit2", 2'b10, 3'd1, 4'd1, 1'b1);
        repeat (8) tick();
        check_all("hold_play2", 2'b01, 3'd1, 4'd1, 1'b0);
        tick();
        check_all("hold_over", 2'b11, 3'd0, 4'd1, 1'b0);
        tick();
        check_all("hold_over_stay", 2'b11, 3'd0, 4'd1, 1'b0);
        collision = 1'b0;
        start = 1'b1;
        tick();
        check_all("restart1", 2'b01, 3'd3, 4'd1, 1'b1);
        start = 1'b0;
        tick();

        // Three separated collisions.
        collision = 1'b1;
        tick();
        check_all("sep_hit1", 2'b10, 3'd2, 4'd1, 1'b1);
        collision = 1'b0;
        start = 1'b1;
        repeat (8) tick();
        check_all("sep_play1", 2'b01, 3'd2, 4'd1, 1'b0);
        start = 1'b0;
        collision = 1'b1;
        tick();
        check_all("sep_hit2", 2'b10, 3'd1, 4'd1, 1'b1);
        collision = 1'b0;
        repeat (8) tick();
        check_all("sep_play2", 2'b01, 3'd1, 4'd1, 1'b0);
        collision = 1'b1;
        tick();
        check_all("sep_over", 2'b11, 3'd0, 4'd1, 1'b0);
        collision = 1'b0;
        start = 1'b1;
        tick();
        check_all("restart2", 2'b01, 3'd3, 4'd1, 1'b1);
        start = 1'b0;
        tick();

        // Nine goal edges walk the level through its wrap.
        for (int i = 0; i < 9; i++) begin
            goal = 1'b1;
            tick();
            check_all("goal_edge", 2'b01, 3'd3, level_seq[i], 1'b1);
            goal = 1'b0;
            tick();
            check_all("goal_low", 2'b01, 3'd3, level_seq[i], 1'b0);
        end

        // Goal held for five cycles counts once.
        goal = 1'b1;
        tick();
        check_all("goal_hold_first", 2'b01, 3'd3, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("goal_hold", 2'b01, 3'd3, 4'd2, 1'b0);
        end
        goal = 1'b0;
        tick();
        goal = 1'b1;
        tick();
        check_all("goal_to3", 2'b01, 3'd3, 4'd3, 1'b1);
        goal = 1'b0;
        tick();
        goal = 1'b1;
        tick();
        check_all("goal_to4", 2'b01, 3'd3, 4'd4, 1'b1);
        goal = 1'b0;
        tick();

        // Collision and goal edge together: collision wins.
        collision = 1'b1;
        goal = 1'b1;
        tick();
        check_all("tie", 2'b10, 3'd2, 4'd4, 1'b1);
        collision = 1'b0;
        goal = 1'b0;
        tick();
        tick();
        check_all("hit_cycle3", 2'b10, 3'd2, 4'd4, 1'b0);

        // Reset mid-HIT.
        rst = 1'b1;
        tick();
        check_all("reset_mid_hit", 2'b00, 3'd3, 4'd1, 1'b0);
        rst = 1'b0;
        tick();
        check_all("idle_after_reset", 2'b00, 3'd3, 4'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
